// File: rtl/decode_input_latch.sv
// decode_input_latch: consumer end of the instruction-buffer -> decode handshake.
// Captures up to three in-order instructions per cycle into a 3-entry compacting
// register stage and presents them to rename with a per-lane valid/ready handshake.
// Optional build macro DECODE_LATCH_READY_BYPASS_EN: decode_ready_o also counts
// entries that rename accepts this cycle (combinational rename_ready_i -> decode_ready_o).
module decode_input_latch #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [2:0]                 decode_valid_i,
    input  logic [DATA_WIDTH-1:0]      instruction_i_0,
    input  logic [DATA_WIDTH-1:0]      instruction_i_1,
    input  logic [DATA_WIDTH-1:0]      instruction_i_2,
    input  logic [DATA_WIDTH-1:0]      pc_i_0,
    input  logic [DATA_WIDTH-1:0]      pc_i_1,
    input  logic [DATA_WIDTH-1:0]      pc_i_2,
    input  logic [DATA_WIDTH-1:0]      imm_i_0,
    input  logic [DATA_WIDTH-1:0]      imm_i_1,
    input  logic [DATA_WIDTH-1:0]      imm_i_2,
    input  logic                       branch_prediction_i_0,
    input  logic                       branch_prediction_i_1,
    input  logic                       branch_prediction_i_2,
    output logic [2:0]                 decode_ready_o,
    output logic [2:0]                 rename_valid_o,
    output logic [DATA_WIDTH-1:0]      instruction_o_0,
    output logic [DATA_WIDTH-1:0]      instruction_o_1,
    output logic [DATA_WIDTH-1:0]      instruction_o_2,
    output logic [DATA_WIDTH-1:0]      pc_o_0,
    output logic [DATA_WIDTH-1:0]      pc_o_1,
    output logic [DATA_WIDTH-1:0]      pc_o_2,
    output logic [DATA_WIDTH-1:0]      imm_o_0,
    output logic [DATA_WIDTH-1:0]      imm_o_1,
    output logic [DATA_WIDTH-1:0]      imm_o_2,
    output logic                       branch_prediction_o_0,
    output logic                       branch_prediction_o_1,
    output logic                       branch_prediction_o_2,
    input  logic [2:0]                 rename_ready_i,
    output logic [1:0]                 occupancy_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

    localparam int unsigned LANES = 3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic                  bp;
    } entry_t;

    entry_t                     in_lane [LANES];
    entry_t                     ent_q   [LANES];
    entry_t                     ent_d   [LANES];
    logic [1:0]                 occ_q;
    logic [1:0]                 occ_d;
    logic                       active_q;
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    logic [STALL_CNT_WIDTH-1:0] stall_d;
    logic [1:0]                 acc;
    logic [1:0]                 inc;
    logic [2:0]                 free;
    logic [2:0]                 base;

    // Contiguous low-order mask of n lanes, clamped at three.
    function automatic logic [2:0] fill_mask(input logic [2:0] n);
        case (n)
            3'd0:    fill_mask = 3'b000;
            3'd1:    fill_mask = 3'b001;
            3'd2:    fill_mask = 3'b011;
            default: fill_mask = 3'b111;
        endcase
    endfunction

    // Count of consecutive ones starting at lane 0; a gap ends the count.
    function automatic logic [1:0] lead_ones(input logic [2:0] v);
        if (!v[0])      lead_ones = 2'd0;
        else if (!v[1]) lead_ones = 2'd1;
        else if (!v[2]) lead_ones = 2'd2;
        else            lead_ones = 2'd3;
    endfunction

    // Gather the incoming lanes into entry form.
    always_comb begin
        in_lane[0] = '{instr: instruction_i_0, pc: pc_i_0, imm: imm_i_0, bp: branch_prediction_i_0};
        in_lane[1] = '{instr: instruction_i_1, pc: pc_i_1, imm: imm_i_1, bp: branch_prediction_i_1};
        in_lane[2] = '{instr: instruction_i_2, pc: pc_i_2, imm: imm_i_2, bp: branch_prediction_i_2};
    end

    // Handshake masks and per-cycle accept counts; flush blocks both directions.
    always_comb begin
        rename_valid_o = flush ? 3'b000 : fill_mask({1'b0, occ_q});
        acc            = lead_ones(rename_valid_o & rename_ready_i);
`ifdef DECODE_LATCH_READY_BYPASS_EN
        free           = 3'd3 - {1'b0, occ_q} + {1'b0, acc};
`else
        free           = 3'd3 - {1'b0, occ_q};
`endif
        decode_ready_o = (flush || !active_q) ? 3'b000 : fill_mask(free);
        inc            = lead_ones(decode_valid_i & decode_ready_o);
    end

    // Compact surviving entries down by acc, then append the captured lanes behind them.
    always_comb begin
        base  = {1'b0, occ_q} - {1'b0, acc};
        occ_d = flush ? 2'd0 : 2'(base + {1'b0, inc});
        for (int i = 0; i < int'(LANES); i++) begin
            logic [2:0] src;
            logic [2:0] k;
            src      = 3'(i) + {1'b0, acc};
            k        = 3'(i) - base;
            ent_d[i] = ent_q[i];
            if (src < {1'b0, occ_q}) begin
                ent_d[i] = ent_q[src[1:0]];
            end
            if ((3'(i) >= base) && (k < {1'b0, inc})) begin
                ent_d[i] = in_lane[k[1:0]];
            end
        end
    end

    // Saturating count of cycles where held entries are all refused by rename.
    always_comb begin
        stall_d = stall_q;
        if (!flush && (occ_q != 2'd0) && (acc == 2'd0) && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    // State registers; ready toward the buffer opens one cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q    <= 2'd0;
            active_q <= 1'b0;
            stall_q  <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            active_q <= 1'b1;
            stall_q  <= stall_d;
            for (int i = 0; i < int'(LANES); i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign instruction_o_0       = ent_q[0].instr;
    assign instruction_o_1       = ent_q[1].instr;
    assign instruction_o_2       = ent_q[2].instr;
    assign pc_o_0                = ent_q[0].pc;
    assign pc_o_1                = ent_q[1].pc;
    assign pc_o_2                = ent_q[2].pc;
    assign imm_o_0               = ent_q[0].imm;
    assign imm_o_1               = ent_q[1].imm;
    assign imm_o_2               = ent_q[2].imm;
    assign branch_prediction_o_0 = ent_q[0].bp;
    assign branch_prediction_o_1 = ent_q[1].bp;
    assign branch_prediction_o_2 = ent_q[2].bp;
    assign occupancy_o           = occ_q;
    assign stall_count_o         = stall_q;

endmodule

// File: tb/tb_decode_input_latch.sv
// Testbench for decode_input_latch: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the latch.
module tb_decode_input_latch;

    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 4;
    localparam int          SMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    decode_valid = 3'b000;
    logic [2:0]    rename_ready = 3'b000;
    logic [DW-1:0] li [3];
    logic [DW-1:0] lp [3];
    logic [DW-1:0] lm [3];
    logic          lb [3];
    logic [DW-1:0] io [3];
    logic [DW-1:0] po [3];
    logic [DW-1:0] mo [3];
    logic          bo [3];
    logic [2:0]    decode_ready_o;
    logic [2:0]    rename_valid_o;
    logic [1:0]    occupancy_o;
    logic [SW-1:0] stall_count_o;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic          bp;
    } ment_t;

    ment_t mq[$];
    int    m_stall = 0;
    bit    m_active = 1'b0;
    int    checks = 0;
    int    failures = 0;

    decode_input_latch #(.DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .decode_valid_i(decode_valid),
        .instruction_i_0(li[0]), .instruction_i_1(li[1]), .instruction_i_2(li[2]),
        .pc_i_0(lp[0]), .pc_i_1(lp[1]), .pc_i_2(lp[2]),
        .imm_i_0(lm[0]), .imm_i_1(lm[1]), .imm_i_2(lm[2]),
        .branch_prediction_i_0(lb[0]), .branch_prediction_i_1(lb[1]), .branch_prediction_i_2(lb[2]),
        .decode_ready_o(decode_ready_o), .rename_valid_o(rename_valid_o),
        .instruction_o_0(io[0]), .instruction_o_1(io[1]), .instruction_o_2(io[2]),
        .pc_o_0(po[0]), .pc_o_1(po[1]), .pc_o_2(po[2]),
        .imm_o_0(mo[0]), .imm_o_1(mo[1]), .imm_o_2(mo[2]),
        .branch_prediction_o_0(bo[0]), .branch_prediction_o_1(bo[1]), .branch_prediction_o_2(bo[2]),
        .rename_ready_i(rename_ready),
        .occupancy_o(occupancy_o), .stall_count_o(stall_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_mask(input int n);
        if (n <= 0)      return 3'b000;
        else if (n == 1) return 3'b001;
        else if (n == 2) return 3'b011;
        else             return 3'b111;
    endfunction

    function automatic int lead(input logic [2:0] v);
        int n = 0;
        for (int i = 0; i < 3 && v[i]; i++) n++;
        return n;
    endfunction

    function automatic logic [2:0] exp_rv();
        return flush ? 3'b000 : m_mask(mq.size());
    endfunction

    function automatic logic [2:0] exp_dr();
        int fr;
        if (flush || !m_active || !reset) return 3'b000;
        fr = 3 - mq.size();
`ifdef DECODE_LATCH_READY_BYPASS_EN
        fr = fr + lead(exp_rv() & rename_ready);
`endif
        if (fr > 3) fr = 3;
        return m_mask(fr);
    endfunction

    task automatic drive(input logic [2:0] dv, input logic [2:0] rr, input bit fl, input logic [DW-1:0] pc0);
        decode_valid = dv;
        rename_ready = rr;
        flush        = fl;
        for (int i = 0; i < 3; i++) begin
            li[i] = $urandom;
            lp[i] = pc0 + DW'(4 * i);
            lm[i] = $urandom;
            lb[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic cycle(input logic [2:0] dv, input logic [2:0] rr, input bit fl, input logic [DW-1:0] pc0);
        @(negedge clk);
        drive(dv, rr, fl, pc0);
        #1;
    endtask

    // Apply one clock edge's worth of behaviour to the reference model.
    task automatic advance();
        int acc;
        int inc;
        if (!reset) begin
            mq.delete();
            m_stall  = 0;
            m_active = 1'b0;
            return;
        end
        acc = lead(exp_rv() & rename_ready);
        inc = lead(decode_valid & exp_dr());
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && acc == 0) m_stall = (m_stall + 1 > SMAX) ? SMAX : m_stall + 1;
            repeat (acc) void'(mq.pop_front());
            for (int k = 0; k < inc; k++) mq.push_back('{li[k], lp[k], lm[k], lb[k]});
        end
        m_active = 1'b1;
    endtask

    task automatic to_empty();
        cycle(3'b000, 3'b000, 1'b1, 32'h0);
        advance();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(3'b111, 3'b000, 1'b0, 32'h0);
        advance();
        @(negedge clk); #1;
        checks++; if (decode_ready_o !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", decode_ready_o); end
        checks++; if (rename_valid_o !== 3'b000) begin failures++; $display("FAIL rst_valid got=%b exp=000", rename_valid_o); end
        checks++; if (occupancy_o !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy_o); end
        checks++; if (stall_count_o !== '0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_count_o); end
        checks++; if (po[0] !== '0 || io[0] !== '0 || mo[2] !== '0) begin failures++; $display("FAIL rst_fields got=%h/%h/%h exp=0", po[0], io[0], mo[2]); end
        @(negedge clk);
        reset = 1'b1;
        drive(3'b111, 3'b000, 1'b0, 32'h0);
        #1;
        checks++; if (decode_ready_o !== 3'b000) begin failures++; $display("FAIL rel_ready0 got=%b exp=000", decode_ready_o); end
        advance();
        cycle(3'b111, 3'b000, 1'b0, 32'h0);
        checks++; if (decode_ready_o !== 3'b111) begin failures++; $display("FAIL rel_ready1 got=%b exp=111", decode_ready_o); end
        advance();
        cycle(3'b000, 3'b000, 1'b0, 32'h100);
        checks++; if (occupancy_o !== 2'd3 || rename_valid_o !== 3'b111) begin failures++; $display("FAIL rel_full got occ=%0d rv=%b exp occ=3 rv=111", occupancy_o, rename_valid_o); end
        checks++; if (po[0] !== 32'h0 || po[1] !== 32'h4 || po[2] !== 32'h8) begin failures++; $display("FAIL rel_pcs got=%h,%h,%h exp=0,4,8", po[0], po[1], po[2]); end
        advance();
    endtask

    task automatic test_partial_accept();
        to_empty();
        cycle(3'b111, 3'b000, 1'b0, 32'h10);
        advance();
        cycle(3'b000, 3'b001, 1'b0, 32'h0);
`ifdef DECODE_LATCH_READY_BYPASS_EN
        checks++; if (decode_ready_o !== 3'b001) begin failures++; $display("FAIL pa_ready got=%b exp=001", decode_ready_o); end
`else
        checks++; if (decode_ready_o !== 3'b000) begin failures++; $display("FAIL pa_ready got=%b exp=000", decode_ready_o); end
`endif
        advance();
        cycle(3'b000, 3'b000, 1'b0, 32'h0);
        checks++; if (occupancy_o !== 2'd2 || rename_valid_o !== 3'b011) begin failures++; $display("FAIL pa_occ got occ=%0d rv=%b exp occ=2 rv=011", occupancy_o, rename_valid_o); end
        checks++; if (po[0] !== 32'h14 || po[1] !== 32'h18) begin failures++; $display("FAIL pa_pcs got=%h,%h exp=14,18", po[0], po[1]); end
        advance();
    endtask

    task automatic test_refill();
        to_empty();
        cycle(3'b001, 3'b000, 1'b0, 32'h20);
        advance();
        cycle(3'b111, 3'b000, 1'b0, 32'h24);
        checks++; if (decode_ready_o !== 3'b011) begin failures++; $display("FAIL rf_ready got=%b exp=011", decode_ready_o); end
        advance();
        cycle(3'b000, 3'b000, 1'b0, 32'h0);
        checks++; if (occupancy_o !== 2'd3) begin failures++; $display("FAIL rf_occ got=%0d exp=3", occupancy_o); end
        checks++; if (po[0] !== 32'h20 || po[1] !== 32'h24 || po[2] !== 32'h28) begin failures++; $display("FAIL rf_pcs got=%h,%h,%h exp=20,24,28", po[0], po[1], po[2]); end
        advance();
    endtask

    task automatic test_flush();
        cycle(3'b111, 3'b111, 1'b1, 32'h40);
        checks++; if (decode_ready_o !== 3'b000 || rename_valid_o !== 3'b000) begin failures++; $display("FAIL fl_masks got dr=%b rv=%b exp 000/000", decode_ready_o, rename_valid_o); end
        advance();
        cycle(3'b000, 3'b000, 1'b0, 32'h0);
        checks++; if (occupancy_o !== 2'd0 || decode_ready_o !== 3'b111) begin failures++; $display("FAIL fl_after got occ=%0d dr=%b exp occ=0 dr=111", occupancy_o, decode_ready_o); end
        advance();
    endtask

    task automatic test_stall();
        int base;
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 32'h0);
        #1;
        advance();
        cycle(3'b000, 3'b000, 1'b0, 32'h0);
        reset = 1'b1;
        advance();
        cycle(3'b011, 3'b000, 1'b0, 32'h60);
        advance();
        base = 0;
        repeat (5) begin
            cycle(3'b000, 3'b000, 1'b0, 32'h0);
            advance();
        end
        cycle(3'b000, 3'b110, 1'b0, 32'h0);
        checks++; if (stall_count_o !== SW'(base + 5)) begin failures++; $display("FAIL st_five got=%0d exp=%0d", stall_count_o, base + 5); end
        checks++; if (occupancy_o !== 2'd2) begin failures++; $display("FAIL st_occ got=%0d exp=2", occupancy_o); end
        advance();
        cycle(3'b000, 3'b000, 1'b0, 32'h0);
        checks++; if (stall_count_o !== SW'(base + 6)) begin failures++; $display("FAIL st_gap got=%0d exp=%0d", stall_count_o, base + 6); end
        advance();
        repeat (12) begin
            cycle(3'b000, 3'b000, 1'b0, 32'h0);
            advance();
        end
        cycle(3'b000, 3'b000, 1'b0, 32'h0);
        checks++; if (stall_count_o !== SW'(SMAX)) begin failures++; $display("FAIL st_sat got=%0d exp=%0d", stall_count_o, SMAX); end
        advance();
    endtask

    task automatic test_bypass();
`ifdef DECODE_LATCH_READY_BYPASS_EN
        to_empty();
        cycle(3'b111, 3'b000, 1'b0, 32'h80);
        advance();
        for (int c = 0; c < 4; c++) begin
            logic [DW-1:0] exp_pc;
            exp_pc = (c == 0) ? 32'h80 : 32'h100 + DW'(12 * (c - 1));
            cycle(3'b111, 3'b111, 1'b0, 32'h100 + DW'(12 * c));
            checks++; if (decode_ready_o !== 3'b111) begin failures++; $display("FAIL bp_ready%0d got=%b exp=111", c, decode_ready_o); end
            checks++; if (occupancy_o !== 2'd3 || po[0] !== exp_pc) begin failures++; $display("FAIL bp_data%0d got occ=%0d pc=%h exp occ=3 pc=%h", c, occupancy_o, po[0], exp_pc); end
            advance();
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [2:0] e_dr;
            logic [2:0] e_rv;
            cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC);
            e_dr = exp_dr();
            e_rv = exp_rv();
            checks++; if (decode_ready_o !== e_dr) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, decode_ready_o, e_dr); end
            checks++; if (rename_valid_o !== e_rv) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, rename_valid_o, e_rv); end
            checks++; if (occupancy_o !== 2'(mq.size())) begin failures++; $display("FAIL rnd_occ n=%0d got=%0d exp=%0d", n, occupancy_o, mq.size()); end
            checks++; if (stall_count_o !== SW'(m_stall)) begin failures++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall_count_o, m_stall); end
            for (int i = 0; i < mq.size(); i++) begin
                checks++;
                if (io[i] !== mq[i].instr || po[i] !== mq[i].pc || mo[i] !== mq[i].imm || bo[i] !== mq[i].bp) begin
                    failures++;
                    $display("FAIL rnd_entry n=%0d e=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", n, i,
                             io[i], po[i], mo[i], bo[i], mq[i].instr, mq[i].pc, mq[i].imm, mq[i].bp);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        cycle(3'b111, 3'b000, 1'b0, 32'h200);
        advance();
        @(posedge clk);
        #2;
        decode_valid = 3'b111;
        reset = 1'b0;
        #1;
        checks++; if (occupancy_o !== 2'd0 || rename_valid_o !== 3'b000 || decode_ready_o !== 3'b000) begin failures++; $display("FAIL rm_clear got occ=%0d rv=%b dr=%b exp 0/000/000", occupancy_o, rename_valid_o, decode_ready_o); end
        checks++; if (stall_count_o !== '0 || po[0] !== '0) begin failures++; $display("FAIL rm_state got stall=%0d pc0=%h exp 0/0", stall_count_o, po[0]); end
        advance();
        cycle(3'b111, 3'b000, 1'b0, 32'h300);
        reset = 1'b1;
        advance();
        cycle(3'b111, 3'b000, 1'b0, 32'h300);
        checks++; if (decode_ready_o !== 3'b111 || occupancy_o !== 2'd0) begin failures++; $display("FAIL rm_release got dr=%b occ=%0d exp 111/0", decode_ready_o, occupancy_o); end
        advance();
    endtask

    initial begin
        test_reset();
        test_partial_accept();
        test_refill();
        test_flush();
        test_stall();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
